alu_nibble_sequencer: RTL and testbench
=======================================

Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that runs a 4*NIBBLES-bit ALU operation through the existing combinational 4-bit ALU slice, one nibble per cycle, LSB nibble first.
- Sits directly upstream of the slice, driving its operand, op, carry and less inputs.
- Also sits directly downstream of it, registering the slice's result, cout, set and overflow.
- Valid/ready handshake on both sides; produces the wide result plus cout, overflow and zero flags.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES is the operand width; legal range 2..8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  high only in IDLE
in_a  input  W  operand A
in_b  input  W  operand B
in_op  input  3  slice op code; 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; in_op[2] = subtract
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  W  final result
out_cout  output  1  carry out of top nibble
out_overflow  output  1  signed overflow of top nibble
out_zero  output  1  out_result == 0
slice_a  output  4  nibble of A to slice
slice_b  output  4  nibble of B to slice
slice_cin  output  1  carry into slice
slice_less  output  1  slice less input; always 0
slice_op  output  3  latched op to slice
slice_result  input  4  slice result
slice_cout  input  1  slice carry out
slice_set  input  1  slice set (sum MSB)
slice_overflow  input  1  slice overflow

Behaviour:
- Single clock domain; all state updates on rising clk.
- Reset (synchronous, active-high) forces the following, regardless of state:
  - state=IDLE; in_ready=1 after reset.
  - out_valid=0; out_result=0; out_cout=0; out_overflow=0; out_zero=0.
  - Nibble counter=0; carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b, in_op; count=0; carry reg=in_op[2]; go RUN.
- RUN (count = 0..NIBBLES-1):
  - slice_a=A[4*count+3:4*count], slice_b likewise, slice_cin=carry reg, slice_op=latched op, slice_less=0.
  - Each cycle: result[4*count+3:4*count] <= slice_result; carry reg <= slice_cout; count++.
  - At count==NIBBLES-1, also capture slice_cout, slice_set and slice_overflow, then go DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready=1.
  - On the handshake cycle go IDLE. in_ready stays 0 during DONE, so there is no same-cycle re-accept.
- SLT (op 111): out_result = {W-1 zeros, slt_bit}, with slt_bit defined under Optional Feature.
- out_zero is computed on the final out_result, after SLT substitution.
- out_cout and out_overflow come from the top nibble for every op; for AND/OR they carry whatever the slice produced and are not meaningful.
- Undefined op codes pass to the slice unchanged with cin=op[2]; the result is whatever the slice produces.
- Latency: accept at edge T; RUN occupies T+1..T+NIBBLES; out_valid is high from cycle T+NIBBLES+1.
- Throughput: one op per NIBBLES+2 cycles minimum.
- In IDLE and DONE: slice_a=0, slice_b=0, slice_cin=0, slice_op=latched op.
- Slice inputs are sampled only by registers; there is no combinational in->out path.
- Reset mid-RUN or mid-DONE aborts the op. Partial results are discarded and no out_valid pulse is produced.
- in_a, in_b and in_op changing after accept have no effect.

Optional Feature:
- Macro ALU_SEQ_SLT_SIGNED_FIX_EN.
- Defined: slt_bit = final slice_set XOR final slice_overflow. This gives a correct signed compare including overflow cases.
- Undefined: slt_bit = final slice_set (raw sign of A-B), matching the classic slice behaviour.

Test Plan:
- ADD: a=0x7FFF, b=0x0001, op=010 (NIBBLES=4) -> out_result=0x8000, overflow=1, cout=0, zero=0; out_valid exactly 5 cycles after accept edge.
- SUB: a=0x1234, b=0x1234, op=110 -> slice_cin=1 on nibble 0; result=0x0000, zero=1, cout=1, overflow=0.
- SLT: a=0x8000, b=0x0001, op=111 -> with macro result=0x0001, zero=0; without macro result=0x0000, zero=1.
- AND: a=0xF0F0, b=0xFF00, op=000 -> slice_cin=0 on first nibble; slice_a sequence 0x0,0xF,0x0,0xF; result=0xF000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored; after out_ready=1, in_ready=1 next cycle.
- Reset mid-RUN: assert reset at count=2 -> next cycle IDLE, in_ready=1, out_valid=0, all flags 0; a following op completes correctly.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - nibble-serial controller for a 4-bit combinational ALU slice
//
// Runs a W = 4*NIBBLES bit operation through an external 4-bit ALU slice,
// one nibble per cycle, LSB nibble first.
// Optional feature macro: ALU_SEQ_SLT_SIGNED_FIX_EN (SLT uses set ^ overflow).
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready           request handshake (ready only in IDLE)
//   in_a, in_b [W], in_op [3]   operands and slice op code (in_op[2] = subtract)
//   out_valid/out_ready         result handshake
//   out_result [W]              final result (SLT substituted)
//   out_cout, out_overflow      carry / signed overflow of the top nibble
//   out_zero                    out_result == 0
//   slice_a/b [4], slice_cin,
//   slice_less, slice_op [3]    drive to the slice
//   slice_result [4], slice_cout,
//   slice_set, slice_overflow   returned from the slice
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_cout,
  output logic                 out_overflow,
  output logic                 out_zero,
  output logic [3:0]           slice_a,
  output logic [3:0]           slice_b,
  output logic                 slice_cin,
  output logic                 slice_less,
  output logic [2:0]           slice_op,
  input  logic [3:0]           slice_result,
  input  logic                 slice_cout,
  input  logic                 slice_set,
  input  logic                 slice_overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    res_q, res_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  // Bit offset of the active nibble; width always covers W-1.
  logic [CW+1:0]   base;
  logic            slt_bit;

  assign base = {count_q, 2'b00};

`ifdef ALU_SEQ_SLT_SIGNED_FIX_EN
  // Sign of A-B corrected for overflow: a true signed less-than.
  assign slt_bit = slice_set ^ slice_overflow;
`else
  // Raw sign of A-B, as the classic slice chain reports it.
  assign slt_bit = slice_set;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    slice_a    = 4'h0;
    slice_b    = 4'h0;
    slice_cin  = 1'b0;
    slice_less = 1'b0;
    slice_op   = op_q;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          count_d = '0;
          carry_d = in_op[2];
          state_d = RUN;
        end
      end
      RUN: begin
        slice_a   = a_q[base +: 4];
        slice_b   = b_q[base +: 4];
        slice_cin = carry_q;
        res_d[base +: 4] = slice_result;
        carry_d   = slice_cout;
        count_d   = count_q + 1'b1;
        if (count_q == LAST) begin
          cout_d  = slice_cout;
          ovf_d   = slice_overflow;
          if (op_q == OP_SLT) begin
            res_d = W'(slt_bit);
          end
          // Zero flag reflects the result after SLT substitution.
          zero_d  = (res_d == '0);
          count_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_result   = res_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - scoreboard bench for alu_nibble_sequencer with a behavioural 4-bit slice
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_cout, out_overflow, out_zero;
  logic [3:0]   slice_a, slice_b, slice_result;
  logic         slice_cin, slice_less, slice_cout, slice_set, slice_overflow;
  logic [2:0]   slice_op;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_zero(out_zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_less(slice_less), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout),
    .slice_set(slice_set), .slice_overflow(slice_overflow)
  );

  // Behavioural 4-bit ALU slice.
  logic [3:0] beff;
  logic [4:0] sum;
  always_comb begin
    beff = slice_op[2] ? ~slice_b : slice_b;
    sum  = {1'b0, slice_a} + {1'b0, beff} + {4'b0, slice_cin};
    case (slice_op[1:0])
      2'b00:   slice_result = slice_a & slice_b;
      2'b01:   slice_result = slice_a | slice_b;
      2'b10:   slice_result = sum[3:0];
      default: slice_result = {3'b000, slice_less};
    endcase
    slice_cout     = sum[4];
    slice_set      = sum[3];
    slice_overflow = (slice_a[3] == beff[3]) && (sum[3] != slice_a[3]);
  end

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         chk_flags;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one pop per completed output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_result), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(out_result), 32'(e.res));
        check("zero", 32'(out_zero), 32'(e.zero));
        if (e.chk_flags) begin
          check("cout", 32'(out_cout), 32'(e.cout));
          check("overflow", 32'(out_overflow), 32'(e.ovf));
        end
      end
    end
  end

  // Drives one request and returns #1 after the accept edge (period 1 of RUN).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input logic push, input exp_t e);
    @(posedge clk); #1;
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    if (push) exp_q.push_back(e);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = '1; in_b = '1; in_op = 3'b011;  // post-accept changes must not matter
  endtask

  // Waits for out_valid, returning the period index (1 = first period after accept).
  task automatic wait_done(input int start, output int p);
    p = start;
    while (!out_valid && p < 30) begin
      @(posedge clk); #1;
      p++;
    end
    if (!out_valid) check("timeout_out_valid", 32'd0, 32'd1);
  endtask

  task automatic finish_handshake();
    @(posedge clk); #1;
  endtask

  exp_t e;
  int p;
  logic [3:0] seq [4];

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_flags", {29'd0, out_cout, out_overflow, out_zero}, 32'd0);

    // ADD with signed overflow, plus latency.
    e = '{res: 16'h8000, cout: 1'b0, ovf: 1'b1, zero: 1'b0, chk_flags: 1'b1};
    issue(16'h7FFF, 16'h0001, 3'b010, 1'b1, e);
    check("run_in_ready", 32'(in_ready), 32'd0);
    wait_done(1, p);
    check("latency_period", 32'(p), 32'd5);
    finish_handshake();

    // SUB equal operands.
    e = '{res: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1, chk_flags: 1'b1};
    issue(16'h1234, 16'h1234, 3'b110, 1'b1, e);
    check("sub_cin_n0", 32'(slice_cin), 32'd1);
    check("sub_slice_a_n0", 32'(slice_a), 32'h4);
    check("slice_less", 32'(slice_less), 32'd0);
    wait_done(1, p);
    finish_handshake();

    // SLT where A-B overflows.
`ifdef ALU_SEQ_SLT_SIGNED_FIX_EN
    e = '{res: 16'h0001, cout: 1'b1, ovf: 1'b1, zero: 1'b0, chk_flags: 1'b1};
`else
    e = '{res: 16'h0000, cout: 1'b1, ovf: 1'b1, zero: 1'b1, chk_flags: 1'b1};
`endif
    issue(16'h8000, 16'h0001, 3'b111, 1'b1, e);
    wait_done(1, p);
    finish_handshake();

    // AND with nibble sequence capture.
    e = '{res: 16'hF000, cout: 1'b0, ovf: 1'b0, zero: 1'b0, chk_flags: 1'b0};
    issue(16'hF0F0, 16'hFF00, 3'b000, 1'b1, e);
    check("and_cin_n0", 32'(slice_cin), 32'd0);
    for (int i = 0; i < 4; i++) begin
      seq[i] = slice_a;
      if (i < 3) begin @(posedge clk); #1; end
    end
    check("and_seq_n0", 32'(seq[0]), 32'h0);
    check("and_seq_n1", 32'(seq[1]), 32'hF);
    check("and_seq_n2", 32'(seq[2]), 32'h0);
    check("and_seq_n3", 32'(seq[3]), 32'hF);
    wait_done(4, p);
    check("idle_slice_a", 32'(slice_a), 32'h0);
    finish_handshake();

    // OR.
    e = '{res: 16'h1234, cout: 1'b0, ovf: 1'b0, zero: 1'b0, chk_flags: 1'b0};
    issue(16'h1200, 16'h0034, 3'b001, 1'b1, e);
    wait_done(1, p);
    finish_handshake();

    // Backpressure: hold DONE for 3 cycles, offer a second request meanwhile.
    out_ready = 1'b0;
    e = '{res: 16'h0003, cout: 1'b0, ovf: 1'b0, zero: 1'b0, chk_flags: 1'b1};
    issue(16'h0001, 16'h0002, 3'b010, 1'b1, e);
    wait_done(1, p);
    in_a = 16'h5555; in_b = 16'h1111; in_op = 3'b010; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", 32'(out_result), 32'h0003);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);

    // Reset mid-RUN at count 2.
    issue(16'h1111, 16'h1111, 3'b010, 1'b0, e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_result", 32'(out_result), 32'd0);
    check("mrst_flags", {29'd0, out_cout, out_overflow, out_zero}, 32'd0);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("mrst_no_valid", 32'(out_valid), 32'd0);
    end

    e = '{res: 16'h0100, cout: 1'b0, ovf: 1'b0, zero: 1'b0, chk_flags: 1'b1};
    issue(16'h00FF, 16'h0001, 3'b010, 1'b1, e);
    wait_done(1, p);
    finish_handshake();

    repeat (2) @(posedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
